// File: rtl/tl_pkg.sv
// rtl/tl_pkg.sv - shared types and constants for the multi-approach traffic-light sequencer
// Contents:
//   state_t  : sequencer phases IDLE, GREEN, YELLOW, CLEAR
//   LED_*    : per-approach lamp codes (one-hot red/yellow/green)
//   idx_w()  : width of an approach index for a given approach count
package tl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GREEN  = 2'd1,
    YELLOW = 2'd2,
    CLEAR  = 2'd3
  } state_t;

  localparam logic [2:0] LED_RED = 3'b001;
  localparam logic [2:0] LED_YEL = 3'b010;
  localparam logic [2:0] LED_GRN = 3'b100;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tl_rr_arbiter.sv
// rtl/tl_rr_arbiter.sv - combinational round-robin winner selection
// Ports:
//   req   in  NUM_CH  request vector
//   ptr   in  IW      index of the last granted approach; search starts at ptr+1
//   valid out 1       some request is present
//   idx   out IW      winning approach index (0 when valid=0)
module tl_rr_arbiter
  import tl_pkg::*;
#(
  parameter  int NUM_CH = 4,
  localparam int IW     = idx_w(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [IW-1:0]     ptr,
  output logic              valid,
  output logic [IW-1:0]     idx
);

  always_comb begin
    int c;
    logic [IW-1:0] cidx;
    valid = 1'b0;
    idx   = '0;
    c     = 0;
    cidx  = '0;
    // Walk from the farthest candidate to the nearest so the last hit,
    // i.e. the one closest after ptr, is the one that sticks.
    for (int k = NUM_CH; k >= 1; k--) begin
      c    = (int'(ptr) + k) % NUM_CH;
      cidx = IW'(c);
      if (req[cidx]) begin
        valid = 1'b1;
        idx   = cidx;
      end
    end
  end

endmodule

// File: rtl/multi_road_controller.sv
// rtl/multi_road_controller.sv - N-approach round-robin traffic-light sequencer
// Ports:
//   clk        in  1         system clock, rising edge
//   rst        in  1         synchronous active-high reset
//   tick       in  1         timebase strobe; timer advances only when high
//   req        in  NUM_CH    per-approach request, level-sensitive
//   preempt    in  1         (TL_PREEMPT_EN only) preemption request
//   preempt_ch in  IW        (TL_PREEMPT_EN only) approach to preempt for
//   led        out 3*NUM_CH  lamp code per approach, slice [3i+2:3i]
//   active_ch  out IW        approach currently green or yellow
//   busy       out 1         high in GREEN, YELLOW and CLEAR
// Optional feature macro: TL_PREEMPT_EN
module multi_road_controller
  import tl_pkg::*;
#(
  parameter  int NUM_CH       = 4,
  parameter  int CNT_W        = 8,
  parameter  int GREEN_TICKS  = 30,
  parameter  int YELLOW_TICKS = 5,
  parameter  int CLEAR_TICKS  = 2,
  localparam int IW           = idx_w(NUM_CH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                tick,
  input  logic [NUM_CH-1:0]   req,
`ifdef TL_PREEMPT_EN
  input  logic                preempt,
  input  logic [IW-1:0]       preempt_ch,
`endif
  output logic [3*NUM_CH-1:0] led,
  output logic [IW-1:0]       active_ch,
  output logic                busy
);

  localparam logic [CNT_W-1:0] G_LOAD = CNT_W'(GREEN_TICKS - 1);
  localparam logic [CNT_W-1:0] Y_LOAD = CNT_W'(YELLOW_TICKS - 1);
  localparam logic [CNT_W-1:0] C_LOAD = CNT_W'(CLEAR_TICKS - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  timer_q;
  logic [IW-1:0]     ptr_q, ch_q;
  logic              min_done_q;   // minimum green has elapsed; resting in green

  logic              expired;
  logic              others;
  logic [NUM_CH-1:0] act_mask;
  logic              rr_valid;
  logic [IW-1:0]     rr_idx;
  logic              grant_valid;
  logic [IW-1:0]     grant_idx;

  tl_rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
    .req   (req),
    .ptr   (ptr_q),
    .valid (rr_valid),
    .idx   (rr_idx)
  );

  assign expired   = tick && (timer_q == '0);
  assign act_mask  = NUM_CH'(1) << ch_q;
  assign others    = |(req & ~act_mask);
  assign active_ch = ch_q;

`ifdef TL_PREEMPT_EN
  logic pre_ok;
  assign pre_ok      = preempt && (int'(preempt_ch) < NUM_CH);
  assign grant_valid = pre_ok ? 1'b1 : rr_valid;
  assign grant_idx   = pre_ok ? preempt_ch : rr_idx;
`else
  assign grant_valid = rr_valid;
  assign grant_idx   = rr_idx;
`endif

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    led     = {NUM_CH{LED_RED}};
    busy    = 1'b1;
    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (grant_valid) state_d = GREEN;
      end
      GREEN: begin
        led[3*int'(ch_q) +: 3] = LED_GRN;
        // Leaving needs the minimum green served (now or earlier) and a competitor.
        if ((expired || min_done_q) && others) state_d = YELLOW;
`ifdef TL_PREEMPT_EN
        if (pre_ok) state_d = (preempt_ch != ch_q) ? YELLOW : GREEN;
`endif
      end
      YELLOW: begin
        led[3*int'(ch_q) +: 3] = LED_YEL;
        if (expired) state_d = CLEAR;
      end
      CLEAR: begin
        if (expired) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      timer_q    <= '0;
      ptr_q      <= IW'(NUM_CH - 1);
      ch_q       <= '0;
      min_done_q <= 1'b0;
    end else begin
      if (state_q == IDLE && state_d == GREEN) begin
        ptr_q      <= grant_idx;
        ch_q       <= grant_idx;
        min_done_q <= 1'b0;
      end else if (state_q == GREEN && expired) begin
        min_done_q <= 1'b1;
      end

      // Reload on every phase change; otherwise count down and park at zero.
      if (state_d != state_q) begin
        case (state_d)
          GREEN:   timer_q <= G_LOAD;
          YELLOW:  timer_q <= Y_LOAD;
          CLEAR:   timer_q <= C_LOAD;
          default: timer_q <= '0;
        endcase
      end else if (tick && timer_q != '0) begin
        timer_q <= timer_q - CNT_W'(1);
      end
    end
  end

endmodule

// File: doc/multi_road_controller.md
Name: multi_road_controller

Overview:
Parametrised N-approach traffic-light sequencer. It is the generalised successor of the single country-road controller. Each approach raises a request; the block grants one approach green at a time by round-robin, then runs that approach through yellow and an all-red clearance. Durations are counted by an internal timer clocked by an external tick strobe. The block sits between the intersection request/sensor logic and the lamp drivers.

Parameters:
NUM_CH, 4, number of approaches (2..8)
CNT_W, 8, timer width in bits
GREEN_TICKS, 30, minimum green duration in ticks (1..2^CNT_W-1)
YELLOW_TICKS, 5, yellow duration in ticks (1..2^CNT_W-1)
CLEAR_TICKS, 2, all-red clearance duration in ticks (1..2^CNT_W-1)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
tick  in  1  single-cycle timebase strobe; the timer advances only when tick=1
req  in  NUM_CH  per-approach request, level-sensitive
led  out  3*NUM_CH  lamp code per approach, slice [3i+2:3i]: 001=red, 010=yellow, 100=green
active_ch  out  $clog2(NUM_CH)  index of the approach currently green or yellow
busy  out  1  high in GREEN, YELLOW and CLEAR

Behaviour:
- Interface decision: one clock (clk); reset rst is synchronous and active-high.
- Reset: state=IDLE, timer=0, rr pointer=NUM_CH-1, active_ch=0, busy=0, all led slices=001.
- States: IDLE, GREEN, YELLOW, CLEAR.
- Timer: on state entry it is loaded with DURATION-1. It decrements on each cycle with tick=1. Expiry = (timer==0 && tick). Timeout therefore occurs on the DURATION-th tick after entry.
- IDLE: all red. If req is non-zero, a winner is chosen by round-robin, searching from ptr+1 upward with wrap to 0. Next cycle: GREEN with active_ch=winner and ptr=winner. If req is zero, the block stays in IDLE.
- GREEN: only led[active_ch]=100; all other slices are 001.
  - On expiry, if any other approach's req is high, go to YELLOW.
  - On expiry with no other requests, rest in green. The timer stays at 0, and the block goes to YELLOW on the first cycle any other req is high; no tick is needed.
- YELLOW: led[active_ch]=010. On expiry go to CLEAR.
- CLEAR: all red; active_ch holds its value. On expiry go to IDLE. Arbitration happens in IDLE, so there is one extra all-red cycle before the next green.
- A req deasserting during GREEN does not shorten GREEN_TICKS.
- Simultaneous requests are resolved strictly by round-robin. No approach waits more than NUM_CH-1 other greens.
- Sole requester: an approach that requests again after its own cycle is granted again; the pointer wrap returns it.
- Every led slice is always exactly one-hot. Two slices are never non-red at the same time.
- Reset mid-operation: immediate return to IDLE with all-red on the next clock edge, regardless of state or tick.

Optional Feature:
Macro TL_PREEMPT_EN. When defined, two ports are added: preempt (in, 1) and preempt_ch (in, $clog2(NUM_CH)).
- IDLE, preempt=1: preempt_ch is granted directly, bypassing round-robin; the pointer is set to preempt_ch.
- GREEN, preempt=1 and active_ch != preempt_ch: go to YELLOW on the next cycle, ignoring the minimum green.
- GREEN, preempt=1 and active_ch == preempt_ch: hold GREEN regardless of expiry for as long as preempt=1.
- YELLOW or CLEAR: the sequence completes normally; the IDLE rule then applies.
- preempt_ch >= NUM_CH is ignored.

Without the macro, these ports do not exist and there is no preemption logic.

Decomposition:
- Package tl_pkg:
  - state enum (IDLE, GREEN, YELLOW, CLEAR)
  - LED constants LED_RED=3'b001, LED_YEL=3'b010, LED_GRN=3'b100
  - function computing the index width
- Sub-module tl_rr_arbiter: combinational round-robin winner given req and ptr. Outputs valid and index. Parametrised by NUM_CH.

Test Plan (NUM_CH=4, GREEN=3, YELLOW=2, CLEAR=1, tick=1 every cycle unless stated):
1. rst=1 for 2 cycles with req=4'b1111 -> led=12'h249 (all red), busy=0; rst is honoured synchronously only.
2. req=4'b0100 from IDLE -> GREEN ch2 next cycle, 3 cycles green. Then rest in green while req stays 4'b0100. Then req=4'b0101 -> YELLOW 2 cycles, CLEAR 1, IDLE 1, GREEN ch0.
3. req=4'b1111 held -> green order 0,1,2,3,0. Each green lasts 3 cycles and each full period is 7 cycles.
4. tick every 4th cycle, req=4'b0011 -> ch0 GREEN lasts 12 cycles, YELLOW 8, CLEAR 4.
5. rst asserted in the middle of YELLOW of ch1 -> next edge gives all red, IDLE, pointer=3; the next grant with req=4'b1111 is ch0.
6. (TL_PREEMPT_EN) ch0 GREEN cycle 1, preempt=1, preempt_ch=3 -> YELLOW ch0 next cycle, CLEAR, then GREEN ch3, held while preempt=1 even with req=4'b0111.
